// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between operand fetch, alu_seq and writeback.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       operation;
   logic [WIDTH-1:0] operand1;
   logic [WIDTH-1:0] operand2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             flag_z;
   logic             flag_c;
   logic             flag_n;

   modport master (
      output in_valid, operation, operand1, operand2, out_ready,
      input  in_ready, out_valid, result, flag_z, flag_c, flag_n
   );

   modport slave (
      input  in_valid, operation, operand1, operand2, out_ready,
      output in_ready, out_valid, result, flag_z, flag_c, flag_n
   );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; shifts iterate one bit per cycle
// unless ALU_SEQ_BARREL_EN is defined, which selects a single-cycle barrel shifter.
module alu_seq #(
   parameter int WIDTH = 16
) (
   input logic      clk,
   input logic      rst,
   alu_seq_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] work_r;
   logic [SHW-1:0]   cnt_r;
   logic             right_r;
   logic             arith_r;
   logic             flag_z_r;
   logic             flag_c_r;
   logic             flag_n_r;

   logic             accept_s;
   logic [WIDTH-1:0] neg_s;
   logic             right_s;
   logic [SHW-1:0]   cnt_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   dif_s;
   logic             go_shift_s;
   logic [WIDTH-1:0] disp_res_s;
   logic             disp_c_s;
   logic [WIDTH-1:0] step_s;
   logic             step_c_s;

`ifdef ALU_SEQ_BARREL_EN
   // Returns {last bit shifted out, shifted value}; n == 0 yields carry 0.
   function automatic logic [WIDTH:0] barrel(input logic [WIDTH-1:0] a,
                                             input logic [SHW-1:0]   n,
                                             input logic             right,
                                             input logic             arith);
      logic [WIDTH:0] t;
      if (right) begin
         t = {a, 1'b0};
         if (arith) begin
            t = $unsigned($signed(t) >>> n);
         end else begin
            t = t >> n;
         end
         barrel = {t[0], t[WIDTH:1]};
      end else begin
         barrel = {1'b0, a} << n;
      end
   endfunction
`endif

   assign accept_s      = bus.in_valid & bus.in_ready;
   assign bus.in_ready  = (state_r == IDLE) | ((state_r == HOLD) & bus.out_ready);
   assign bus.out_valid = (state_r == HOLD);
   assign bus.result    = result_r;
   assign bus.flag_z    = flag_z_r;
   assign bus.flag_c    = flag_c_r;
   assign bus.flag_n    = flag_n_r;

   // Decode the presented operation: single-cycle result or shift setup.
   always_comb begin
      neg_s      = '0 - bus.operand2;
      right_s    = bus.operand2[WIDTH-1];
      cnt_s      = right_s ? neg_s[SHW-1:0] : bus.operand2[SHW-1:0];
      sum_s      = {1'b0, bus.operand1} + {1'b0, bus.operand2};
      dif_s      = {1'b0, bus.operand1} - {1'b0, bus.operand2};
      go_shift_s = 1'b0;
      disp_res_s = '0;
      disp_c_s   = 1'b0;
      case (bus.operation)
         3'b000, 3'b001: begin
            if (cnt_s == '0) begin
               disp_res_s = bus.operand1;
               disp_c_s   = 1'b0;
            end else begin
`ifdef ALU_SEQ_BARREL_EN
               {disp_c_s, disp_res_s} = barrel(bus.operand1, cnt_s, right_s, bus.operation[0]);
`else
               go_shift_s = 1'b1;
`endif
            end
         end
         3'b010:  {disp_c_s, disp_res_s} = dif_s;
         3'b011:  disp_res_s = '0;
         3'b100:  {disp_c_s, disp_res_s} = sum_s;
         3'b101:  disp_res_s = bus.operand1 & bus.operand2;
         3'b110:  disp_res_s = bus.operand1 | bus.operand2;
         3'b111:  disp_res_s = ~bus.operand1;
         default: disp_res_s = '0;
      endcase
   end

   // One-bit shift step of the working register.
   always_comb begin
      if (right_r) begin
         step_c_s = work_r[0];
         step_s   = {arith_r & work_r[WIDTH-1], work_r[WIDTH-1:1]};
      end else begin
         step_c_s = work_r[WIDTH-1];
         step_s   = {work_r[WIDTH-2:0], 1'b0};
      end
   end

   // Control FSM with registered result and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         result_r <= '0;
         work_r   <= '0;
         cnt_r    <= '0;
         right_r  <= 1'b0;
         arith_r  <= 1'b0;
         flag_z_r <= 1'b0;
         flag_c_r <= 1'b0;
         flag_n_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE, HOLD: begin
               if (accept_s) begin
                  if (go_shift_s) begin
                     work_r  <= bus.operand1;
                     cnt_r   <= cnt_s;
                     right_r <= right_s;
                     arith_r <= bus.operation[0];
                     state_r <= SHIFT;
                  end else begin
                     result_r <= disp_res_s;
                     flag_c_r <= disp_c_s;
                     flag_z_r <= (disp_res_s == '0);
                     flag_n_r <= disp_res_s[WIDTH-1];
                     state_r  <= HOLD;
                  end
               end else if ((state_r == HOLD) && bus.out_ready) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= state_r;
               end
            end
            SHIFT: begin
               work_r   <= step_s;
               flag_c_r <= step_c_s;
               cnt_r    <= cnt_r - SHW'(1);
               // Last step: the shifted word becomes the visible result.
               if (cnt_r == SHW'(1)) begin
                  result_r <= step_s;
                  flag_z_r <= (step_s == '0);
                  flag_n_r <= step_s[WIDTH-1];
                  state_r  <= HOLD;
               end else begin
                  state_r  <= SHIFT;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table, scoreboard and handshake corner cases.
module tb_alu_seq;
   localparam int WIDTH = 16;
`ifdef ALU_SEQ_BARREL_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        c;
      int          lat;
      bit          is_shift;
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic        c;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   pops = 0;
   exp_t exp_q[$];
   vec_t vecs[20];
   logic [2:0] stream_ops[5];

   alu_seq_if #(.WIDTH(WIDTH)) bus ();
   alu_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int   s;
      e.c = 1'b0;
      case (op)
         3'b010: begin e.res = a - b; e.c = (a < b); end
         3'b100: begin s = int'(a) + int'(b); e.res = s[15:0]; e.c = (s > 65535); end
         3'b101: e.res = a & b;
         3'b110: e.res = a | b;
         3'b111: e.res = ~a;
         default: e.res = 16'h0000;
      endcase
      return e;
   endfunction

   // Scoreboard: compare each consumed result against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            pops++;
            chk("result", 32'(bus.result), 32'(e.res));
            chk("flag_c", 32'(bus.flag_c), 32'(e.c));
            chk("flag_z", 32'(bus.flag_z), 32'(e.res == 16'h0000));
            chk("flag_n", 32'(bus.flag_n), 32'(e.res[15]));
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input exp_t e, input int lat_req, input string name);
      int lat;
      bus.in_valid  = 1'b1;
      bus.operation = op;
      bus.operand1  = a;
      bus.operand2  = b;
      exp_q.push_back(e);
      tick();
      lat = 1;
      bus.in_valid  = 1'b0;
      bus.operation = 3'($urandom);
      bus.operand1  = 16'($urandom);
      bus.operand2  = 16'($urandom);
      while (!bus.out_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'(lat_req));
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      exp_t e;
      int   p0;
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;

      vecs[0]  = '{3'b100, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1,  1'b0};
      vecs[1]  = '{3'b000, 16'h8001, 16'hFFFD, 16'h1000, 1'b0, 4,  1'b1};
      vecs[2]  = '{3'b001, 16'h8000, 16'hFFFF, 16'hC000, 1'b0, 2,  1'b1};
      vecs[3]  = '{3'b000, 16'h1234, 16'hFFF0, 16'h1234, 1'b0, 1,  1'b0};
      vecs[4]  = '{3'b000, 16'h8001, 16'h0001, 16'h0002, 1'b1, 2,  1'b1};
      vecs[5]  = '{3'b001, 16'h0800, 16'h0005, 16'h0000, 1'b1, 6,  1'b1};
      vecs[6]  = '{3'b001, 16'h8000, 16'hFFF1, 16'hFFFF, 1'b0, 16, 1'b1};
      vecs[7]  = '{3'b000, 16'h8000, 16'hFFF1, 16'h0001, 1'b0, 16, 1'b1};
      vecs[8]  = '{3'b000, 16'h0003, 16'hFFFF, 16'h0001, 1'b1, 2,  1'b1};
      vecs[9]  = '{3'b000, 16'h00FF, 16'h000F, 16'h8000, 1'b1, 16, 1'b1};
      vecs[10] = '{3'b010, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1,  1'b0};
      vecs[11] = '{3'b010, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1,  1'b0};
      vecs[12] = '{3'b011, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1,  1'b0};
      vecs[13] = '{3'b101, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1,  1'b0};
      vecs[14] = '{3'b110, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1,  1'b0};
      vecs[15] = '{3'b111, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1,  1'b0};
      vecs[16] = '{3'b100, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1,  1'b0};
      vecs[17] = '{3'b000, 16'h0001, 16'h0010, 16'h0001, 1'b0, 1,  1'b0};
      vecs[18] = '{3'b001, 16'h0001, 16'hFFF0, 16'h0001, 1'b0, 1,  1'b0};
      vecs[19] = '{3'b010, 16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1,  1'b0};
      stream_ops = '{3'b101, 3'b110, 3'b111, 3'b100, 3'b010};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.operation = 3'b000;
      bus.operand1  = 16'h0000;
      bus.operand2  = 16'h0000;
      rst = 1'b1;
      tick(); tick(); tick();
      rst = 1'b0;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_flags", 32'({bus.flag_z, bus.flag_c, bus.flag_n}), 32'd0);

      // Table vectors, issued back to back with out_ready held high.
      for (int i = 0; i < 20; i++) begin
         e.res = vecs[i].res;
         e.c   = vecs[i].c;
         send(vecs[i].op, vecs[i].a, vecs[i].b, e,
              (vecs[i].is_shift && BARREL) ? 1 : vecs[i].lat, $sformatf("vec%0d", i));
      end

      // SUB held while the consumer stalls.
      idle();
      bus.out_ready = 1'b0;
      e.res = 16'hFFFE;
      e.c   = 1'b1;
      send(3'b010, 16'h0003, 16'h0005, e, 1, "sub_hold");
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_result", 32'(bus.result), 32'h0000FFFE);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
         chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("hold_release", 32'(bus.out_valid), 32'd0);

      // Stream of single-cycle ops: one result per cycle.
      idle();
      p0 = pops;
      for (int i = 0; i < 12; i++) begin
         op = stream_ops[$urandom_range(0, 4)];
         a  = 16'($urandom);
         b  = 16'($urandom);
         bus.in_valid  = 1'b1;
         bus.operation = op;
         bus.operand1  = a;
         bus.operand2  = b;
         exp_q.push_back(model(op, a, b));
         tick();
         chk("stream_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid = 1'b0;
      tick();
      chk("stream_count", 32'(pops - p0), 32'd12);

      // Reset during a shift by 10.
      idle();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.operation = 3'b000;
      bus.operand1  = 16'h0001;
      bus.operand2  = 16'h000A;
      tick();
      bus.in_valid = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_result", 32'(bus.result), 32'd0);
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_flags", 32'({bus.flag_z, bus.flag_c, bus.flag_n}), 32'd0);
      bus.out_ready = 1'b1;
      e.res = 16'h3333;
      e.c   = 1'b0;
      send(3'b100, 16'h1111, 16'h2222, e, 1, "add_after_abort");

      // Reset wins over an accept on the same edge.
      idle();
      rst = 1'b1;
      bus.in_valid  = 1'b1;
      bus.operation = 3'b100;
      bus.operand1  = 16'h0001;
      bus.operand2  = 16'h0001;
      tick();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      chk("rst_prio_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_prio_result", 32'(bus.result), 32'd0);
      tick();
      chk("rst_prio_no_result", 32'(bus.out_valid), 32'd0);

      idle();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
